// File: rtl/mips_bus_arbiter.sv
// Two-master / two-slave bus controller for the MIPS SoC.
// Round-robin arbitration between the core (m0) and the debug/DMA loader (m1),
// one outstanding transaction, address MSB selects memory (0) or UART CSRs (1).
// All outputs are registered; slave strobes fire once per access.
module mips_bus_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int UART_ADDR_WIDTH = 3,
  parameter int MEM_LATENCY     = 1,
  parameter int UART_LATENCY    = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  // master 0 (MIPS core)
  input  logic                       m0_req,
  input  logic [ADDR_WIDTH-1:0]      m0_addr,
  input  logic [DATA_WIDTH-1:0]      m0_wr_data,
  input  logic                       m0_wr_en,
  output logic                       m0_ack,
  output logic [DATA_WIDTH-1:0]      m0_rd_data,
  // master 1 (debug / DMA loader)
  input  logic                       m1_req,
  input  logic [ADDR_WIDTH-1:0]      m1_addr,
  input  logic [DATA_WIDTH-1:0]      m1_wr_data,
  input  logic                       m1_wr_en,
  output logic                       m1_ack,
  output logic [DATA_WIDTH-1:0]      m1_rd_data,
  // instruction/data memory
  output logic                       mem_chip_sel,
  output logic [ADDR_WIDTH-2:0]      mem_addr,
  output logic [DATA_WIDTH-1:0]      mem_wr_data,
  output logic                       mem_wr_en,
  input  logic [DATA_WIDTH-1:0]      mem_rd_data,
  // UART CSR block
  output logic [UART_ADDR_WIDTH-1:0] uart_csr_addr,
  output logic [DATA_WIDTH-1:0]      uart_csr_wr_data,
  output logic                       uart_csr_wen,
  output logic                       uart_csr_ren,
  input  logic [DATA_WIDTH-1:0]      uart_csr_rd_data,
  // status
  output logic                       busy
);

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] MEM_LAT_M1  = CNT_W'(MEM_LATENCY - 1);
  localparam logic [CNT_W-1:0] UART_LAT_M1 = CNT_W'(UART_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                     state_q, state_d;
  logic                       id_q, id_d;        // granted master
  logic                       sel_q, sel_d;      // 0 = memory, 1 = UART
  logic                       wr_en_q, wr_en_d;
  logic                       ptr_q, ptr_d;      // master favoured on a tie
  logic [CNT_W-1:0]           cnt_q, cnt_d;

  logic                       mem_chip_sel_q, mem_chip_sel_d;
  logic [ADDR_WIDTH-2:0]      mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]      mem_wr_data_q, mem_wr_data_d;
  logic                       mem_wr_en_q, mem_wr_en_d;
  logic [UART_ADDR_WIDTH-1:0] uart_csr_addr_q, uart_csr_addr_d;
  logic [DATA_WIDTH-1:0]      uart_csr_wr_data_q, uart_csr_wr_data_d;
  logic                       uart_csr_wen_q, uart_csr_wen_d;
  logic                       uart_csr_ren_q, uart_csr_ren_d;
  logic                       m0_ack_q, m0_ack_d;
  logic                       m1_ack_q, m1_ack_d;
  logic [DATA_WIDTH-1:0]      m0_rd_data_q, m0_rd_data_d;
  logic [DATA_WIDTH-1:0]      m1_rd_data_q, m1_rd_data_d;
  logic                       busy_q, busy_d;

  // Arbitration helpers and the value captured at the end of the data phase.
  logic                       gnt;
  logic [ADDR_WIDTH-1:0]      gnt_addr;
  logic [DATA_WIDTH-1:0]      gnt_wr_data;
  logic                       gnt_wr_en;
  logic [DATA_WIDTH-1:0]      cap_data;

  // Pick the requester and the read data that would be captured this cycle.
  always_comb begin
    gnt         = (m0_req && m1_req) ? ptr_q : m1_req;
    gnt_addr    = gnt ? m1_addr    : m0_addr;
    gnt_wr_data = gnt ? m1_wr_data : m0_wr_data;
    gnt_wr_en   = gnt ? m1_wr_en   : m0_wr_en;
    if (wr_en_q)    cap_data = '0;
    else if (sel_q) cap_data = uart_csr_rd_data;
    else            cap_data = mem_rd_data;
  end

  // Next-state and next-output logic; strobes and acks default low every cycle.
  always_comb begin
    state_d            = state_q;
    id_d               = id_q;
    sel_d              = sel_q;
    wr_en_d            = wr_en_q;
    ptr_d              = ptr_q;
    cnt_d              = cnt_q;
    mem_chip_sel_d     = mem_chip_sel_q;
    mem_addr_d         = mem_addr_q;
    mem_wr_data_d      = mem_wr_data_q;
    mem_wr_en_d        = 1'b0;
    uart_csr_addr_d    = uart_csr_addr_q;
    uart_csr_wr_data_d = uart_csr_wr_data_q;
    uart_csr_wen_d     = 1'b0;
    uart_csr_ren_d     = 1'b0;
    m0_ack_d           = 1'b0;
    m1_ack_d           = 1'b0;
    m0_rd_data_d       = '0;
    m1_rd_data_d       = '0;

    case (state_q)
      S_IDLE: begin
        if (m0_req || m1_req) begin
          id_d               = gnt;
          sel_d              = gnt_addr[ADDR_WIDTH-1];
          wr_en_d            = gnt_wr_en;
          mem_addr_d         = gnt_addr[ADDR_WIDTH-2:0];
          uart_csr_addr_d    = gnt_addr[UART_ADDR_WIDTH-1:0];
          mem_wr_data_d      = gnt_wr_data;
          uart_csr_wr_data_d = gnt_wr_data;
          // Strobes are registered, so they are set up here to be live in ISSUE.
          mem_chip_sel_d     = ~gnt_addr[ADDR_WIDTH-1];
          mem_wr_en_d        = ~gnt_addr[ADDR_WIDTH-1] & gnt_wr_en;
          uart_csr_wen_d     =  gnt_addr[ADDR_WIDTH-1] & gnt_wr_en;
          uart_csr_ren_d     =  gnt_addr[ADDR_WIDTH-1] & ~gnt_wr_en;
          cnt_d              = gnt_addr[ADDR_WIDTH-1] ? UART_LAT_M1 : MEM_LAT_M1;
          state_d            = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (cnt_q == '0) begin
          // Single-cycle latency: data is valid during ISSUE itself.
          mem_chip_sel_d = 1'b0;
          m0_ack_d       = ~id_q;
          m1_ack_d       =  id_q;
          m0_rd_data_d   = id_q ? '0 : cap_data;
          m1_rd_data_d   = id_q ? cap_data : '0;
          state_d        = S_DONE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        // Counter reaching zero at this edge marks the capture point.
        if (cnt_q == CNT_W'(1)) begin
          mem_chip_sel_d = 1'b0;
          m0_ack_d       = ~id_q;
          m1_ack_d       =  id_q;
          m0_rd_data_d   = id_q ? '0 : cap_data;
          m1_rd_data_d   = id_q ? cap_data : '0;
          state_d        = S_DONE;
        end
      end
      S_DONE: begin
        ptr_d   = ~id_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset aborts any access without an ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q            <= S_IDLE;
      id_q               <= 1'b0;
      sel_q              <= 1'b0;
      wr_en_q            <= 1'b0;
      ptr_q              <= 1'b0;
      cnt_q              <= '0;
      mem_chip_sel_q     <= 1'b0;
      mem_addr_q         <= '0;
      mem_wr_data_q      <= '0;
      mem_wr_en_q        <= 1'b0;
      uart_csr_addr_q    <= '0;
      uart_csr_wr_data_q <= '0;
      uart_csr_wen_q     <= 1'b0;
      uart_csr_ren_q     <= 1'b0;
      m0_ack_q           <= 1'b0;
      m1_ack_q           <= 1'b0;
      m0_rd_data_q       <= '0;
      m1_rd_data_q       <= '0;
      busy_q             <= 1'b0;
    end else begin
      state_q            <= state_d;
      id_q               <= id_d;
      sel_q              <= sel_d;
      wr_en_q            <= wr_en_d;
      ptr_q              <= ptr_d;
      cnt_q              <= cnt_d;
      mem_chip_sel_q     <= mem_chip_sel_d;
      mem_addr_q         <= mem_addr_d;
      mem_wr_data_q      <= mem_wr_data_d;
      mem_wr_en_q        <= mem_wr_en_d;
      uart_csr_addr_q    <= uart_csr_addr_d;
      uart_csr_wr_data_q <= uart_csr_wr_data_d;
      uart_csr_wen_q     <= uart_csr_wen_d;
      uart_csr_ren_q     <= uart_csr_ren_d;
      m0_ack_q           <= m0_ack_d;
      m1_ack_q           <= m1_ack_d;
      m0_rd_data_q       <= m0_rd_data_d;
      m1_rd_data_q       <= m1_rd_data_d;
      busy_q             <= busy_d;
    end
  end

  assign m0_ack           = m0_ack_q;
  assign m1_ack           = m1_ack_q;
  assign m0_rd_data       = m0_rd_data_q;
  assign m1_rd_data       = m1_rd_data_q;
  assign mem_chip_sel     = mem_chip_sel_q;
  assign mem_addr         = mem_addr_q;
  assign mem_wr_data      = mem_wr_data_q;
  assign mem_wr_en        = mem_wr_en_q;
  assign uart_csr_addr    = uart_csr_addr_q;
  assign uart_csr_wr_data = uart_csr_wr_data_q;
  assign uart_csr_wen     = uart_csr_wen_q;
  assign uart_csr_ren     = uart_csr_ren_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Directed bench for mips_bus_arbiter (MEM_LATENCY=1, UART_LATENCY=2).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Cycle k=1 is the ISSUE cycle following the rising edge that samples a request.
module tb_mips_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_req = 1'b0, m1_req = 1'b0;
  logic [31:0] m0_addr = '0, m1_addr = '0;
  logic [31:0] m0_wr_data = '0, m1_wr_data = '0;
  logic        m0_wr_en = 1'b0, m1_wr_en = 1'b0;
  logic        m0_ack, m1_ack;
  logic [31:0] m0_rd_data, m1_rd_data;
  logic        mem_chip_sel;
  logic [30:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic        mem_wr_en;
  logic [31:0] mem_rd_data = '0;
  logic [2:0]  uart_csr_addr;
  logic [31:0] uart_csr_wr_data;
  logic        uart_csr_wen, uart_csr_ren;
  logic [31:0] uart_csr_rd_data = '0;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mips_bus_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wr_data(m0_wr_data), .m0_wr_en(m0_wr_en),
    .m0_ack(m0_ack), .m0_rd_data(m0_rd_data),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wr_data(m1_wr_data), .m1_wr_en(m1_wr_en),
    .m1_ack(m1_ack), .m1_rd_data(m1_rd_data),
    .mem_chip_sel(mem_chip_sel), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_en(mem_wr_en), .mem_rd_data(mem_rd_data),
    .uart_csr_addr(uart_csr_addr), .uart_csr_wr_data(uart_csr_wr_data),
    .uart_csr_wen(uart_csr_wen), .uart_csr_ren(uart_csr_ren),
    .uart_csr_rd_data(uart_csr_rd_data), .busy(busy)
  );

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if ({m0_ack, m1_ack} !== 2'b00) begin bad++; $display("FAIL reset_acks got=%b want=00", {m0_ack, m1_ack}); end
    total++; if ({mem_chip_sel, mem_wr_en, uart_csr_wen, uart_csr_ren} !== 4'b0000) begin
      bad++; $display("FAIL reset_strobes got=%b want=0000", {mem_chip_sel, mem_wr_en, uart_csr_wen, uart_csr_ren});
    end
    total++; if ({m0_rd_data, m1_rd_data} !== 64'h0) begin bad++; $display("FAIL reset_rd_data got=%h want=0", {m0_rd_data, m1_rd_data}); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b want=0", busy); end
    $display("reset: busy=%b acks=%b", busy, {m0_ack, m1_ack});
  endtask

  task automatic test_mem_read();
    int ack_k = 0, ack_n = 0, cs_n = 0, cs_k = 0, busy_n = 0, oth_n = 0;
    logic [31:0] ack_data = '0;
    logic [30:0] cs_addr = '0;
    m0_addr = 32'h0000_0010; m0_wr_en = 1'b0; mem_rd_data = 32'hDEAD_BEEF; m0_req = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (mem_chip_sel) begin cs_n++; cs_k = k; cs_addr = mem_addr; end
      if (busy) busy_n++;
      if (m1_ack) oth_n++;
      if (m0_ack) begin ack_n++; ack_k = k; ack_data = m0_rd_data; m0_req = 1'b0; end
    end
    total++; if (cs_n !== 1) begin bad++; $display("FAIL memrd_cs_cycles got=%0d want=1", cs_n); end
    total++; if (cs_k !== 1) begin bad++; $display("FAIL memrd_cs_cycle got=%0d want=1", cs_k); end
    total++; if (cs_addr !== 31'h10) begin bad++; $display("FAIL memrd_addr got=%h want=10", cs_addr); end
    total++; if (ack_n !== 1) begin bad++; $display("FAIL memrd_ack_count got=%0d want=1", ack_n); end
    total++; if (ack_k !== 2) begin bad++; $display("FAIL memrd_ack_cycle got=%0d want=2", ack_k); end
    total++; if (ack_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL memrd_data got=%h want=deadbeef", ack_data); end
    total++; if (busy_n !== 2) begin bad++; $display("FAIL memrd_busy_cycles got=%0d want=2", busy_n); end
    total++; if (oth_n !== 0) begin bad++; $display("FAIL memrd_m1_ack got=%0d want=0", oth_n); end
    $display("m0 mem read addr=00000010 ack_cycle=%0d data=%h", ack_k, ack_data);
  endtask

  task automatic test_uart_write();
    int ack_k = 0, ack_n = 0, wen_n = 0, ren_n = 0, cs_n = 0;
    logic [2:0]  wen_addr = '0;
    logic [31:0] wen_data = '0, ack_data = 32'hFFFF_FFFF;
    m1_addr = 32'h8000_0001; m1_wr_data = 32'h41; m1_wr_en = 1'b1; m1_req = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (uart_csr_wen) begin wen_n++; wen_addr = uart_csr_addr; wen_data = uart_csr_wr_data; end
      if (uart_csr_ren) ren_n++;
      if (mem_chip_sel) cs_n++;
      if (m1_ack) begin ack_n++; ack_k = k; ack_data = m1_rd_data; m1_req = 1'b0; end
    end
    total++; if (wen_n !== 1) begin bad++; $display("FAIL uartwr_wen_cycles got=%0d want=1", wen_n); end
    total++; if (wen_addr !== 3'd1) begin bad++; $display("FAIL uartwr_addr got=%0d want=1", wen_addr); end
    total++; if (wen_data !== 32'h41) begin bad++; $display("FAIL uartwr_data got=%h want=41", wen_data); end
    total++; if (ren_n !== 0) begin bad++; $display("FAIL uartwr_ren got=%0d want=0", ren_n); end
    total++; if (cs_n !== 0) begin bad++; $display("FAIL uartwr_mem_cs got=%0d want=0", cs_n); end
    total++; if (ack_k !== 3) begin bad++; $display("FAIL uartwr_ack_cycle got=%0d want=3", ack_k); end
    total++; if (ack_n !== 1) begin bad++; $display("FAIL uartwr_ack_count got=%0d want=1", ack_n); end
    total++; if (ack_data !== 32'h0) begin bad++; $display("FAIL uartwr_rd_data got=%h want=0", ack_data); end
    m1_wr_en = 1'b0;
    $display("m1 uart write addr=80000001 data=41 ack_cycle=%0d", ack_k);
  endtask

  task automatic test_round_robin();
    int ack_n = 0, both_n = 0;
    int cyc[4];
    logic ids[4];
    logic [31:0] dat[4];
    m0_addr = 32'h0000_0100; m1_addr = 32'h0000_0200;
    m0_wr_en = 1'b0; m1_wr_en = 1'b0; mem_rd_data = 32'h0000_1234;
    m0_req = 1'b1; m1_req = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (m0_ack && m1_ack) both_n++;
      if ((m0_ack || m1_ack) && ack_n < 4) begin
        cyc[ack_n] = k; ids[ack_n] = m1_ack; dat[ack_n] = m1_ack ? m1_rd_data : m0_rd_data;
        ack_n++;
        if (ack_n == 4) begin m0_req = 1'b0; m1_req = 1'b0; end
      end
    end
    total++; if (ack_n !== 4) begin bad++; $display("FAIL rr_ack_count got=%0d want=4", ack_n); end
    total++; if (both_n !== 0) begin bad++; $display("FAIL rr_both_acks got=%0d want=0", both_n); end
    for (int i = 0; i < ack_n; i++) begin
      total++; if (ids[i] !== 1'(i % 2)) begin bad++; $display("FAIL rr_grant%0d got=m%0d want=m%0d", i, ids[i], i % 2); end
      total++; if (cyc[i] !== 2 + 3 * i) begin bad++; $display("FAIL rr_cycle%0d got=%0d want=%0d", i, cyc[i], 2 + 3 * i); end
      total++; if (dat[i] !== 32'h1234) begin bad++; $display("FAIL rr_data%0d got=%h want=1234", i, dat[i]); end
      $display("rr ack %0d: m%0d cycle=%0d data=%h", i, ids[i], cyc[i], dat[i]);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_uart_read();
    int ack_k = 0, ack_n = 0, ren_n = 0;
    logic [31:0] ack_data = '0;
    uart_csr_rd_data = 32'h0;
    m0_addr = 32'h8000_0002; m0_wr_en = 1'b0; m0_req = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 2) uart_csr_rd_data = 32'h0000_00A5;
      if (uart_csr_ren) ren_n++;
      if (m0_ack) begin ack_n++; ack_k = k; ack_data = m0_rd_data; m0_req = 1'b0; end
    end
    total++; if (ren_n !== 1) begin bad++; $display("FAIL uartrd_ren_cycles got=%0d want=1", ren_n); end
    total++; if (ack_k !== 3) begin bad++; $display("FAIL uartrd_ack_cycle got=%0d want=3", ack_k); end
    total++; if (ack_data !== 32'hA5) begin bad++; $display("FAIL uartrd_data got=%h want=a5", ack_data); end
    $display("m0 uart read addr=80000002 ack_cycle=%0d data=%h", ack_k, ack_data);
  endtask

  task automatic test_reset_mid();
    int ack_n = 0, first_k = 0;
    logic first_id = 1'b0;
    m1_addr = 32'h8000_0003; m1_wr_en = 1'b0; m1_req = 1'b1;
    @(negedge clk);                // ISSUE
    @(negedge clk);                // WAIT
    rst_n = 1'b0; m1_req = 1'b0;
    #1;
    total++; if ({busy, uart_csr_ren, m0_ack, m1_ack, mem_chip_sel} !== 5'b0) begin
      bad++; $display("FAIL rstmid_outputs got=%b want=00000", {busy, uart_csr_ren, m0_ack, m1_ack, mem_chip_sel});
    end
    total++; if (uart_csr_addr !== 3'd0) begin bad++; $display("FAIL rstmid_uart_addr got=%0d want=0", uart_csr_addr); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (m0_ack || m1_ack) ack_n++;
    end
    total++; if (ack_n !== 0) begin bad++; $display("FAIL rstmid_stray_ack got=%0d want=0", ack_n); end
    m0_addr = 32'h0000_0020; m1_addr = 32'h0000_0030; m0_req = 1'b1; m1_req = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if ((m0_ack || m1_ack) && first_k == 0) begin
        first_k = k; first_id = m1_ack; m0_req = 1'b0; m1_req = 1'b0;
      end
    end
    total++; if (first_k !== 2) begin bad++; $display("FAIL rstmid_first_cycle got=%0d want=2", first_k); end
    total++; if (first_id !== 1'b0) begin bad++; $display("FAIL rstmid_first_grant got=m%0d want=m0", first_id); end
    $display("reset mid-wait: stray_acks=%0d first grant m%0d", ack_n, first_id);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_drop_req();
    int ack_k = 0, ack_n = 0;
    logic [31:0] ack_data = '0;
    logic busy_after = 1'b1;
    uart_csr_rd_data = 32'h0000_0077;
    m1_addr = 32'h8000_0004; m1_wr_en = 1'b0; m1_req = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 2) m1_req = 1'b0;
      if (m1_ack) begin ack_n++; ack_k = k; ack_data = m1_rd_data; end
      if (k == 4) busy_after = busy;
    end
    total++; if (ack_n !== 1) begin bad++; $display("FAIL drop_ack_count got=%0d want=1", ack_n); end
    total++; if (ack_k !== 3) begin bad++; $display("FAIL drop_ack_cycle got=%0d want=3", ack_k); end
    total++; if (ack_data !== 32'h77) begin bad++; $display("FAIL drop_data got=%h want=77", ack_data); end
    total++; if (busy_after !== 1'b0) begin bad++; $display("FAIL drop_idle got=%b want=0", busy_after); end
    $display("m1 uart read with dropped req ack_cycle=%0d data=%h", ack_k, ack_data);
  endtask

  initial begin
    test_reset();
    test_mem_read();
    test_uart_write();
    test_round_robin();
    test_uart_read();
    test_reset_mid();
    test_drop_req();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
